bmp_stream_loader: RTL and testbench
====================================

Name: bmp_stream_loader

Overview:
- Parses a BMP file streamed over the data_io byte interface and writes its pixels into SDRAM as 32-bit words {8'h00,R,G,B}, one word per pixel.
- Generalises the fixed 24-bit, bottom-up-only loader:
  - header-driven width, height, bit depth and orientation;
  - row padding skip;
  - clipping to a parametrised frame buffer;
  - a buffered req/ack toggle write port;
  - a status/error report.
- Sits between data_io and an SDRAM write port; the video scan-out reads the frame buffer at (line*LINE_WORDS + x).

Parameters:
- ADDR_W, 22, SDRAM word address width (32-bit words).
- LINE_WORDS, 512, words per frame-buffer line; power of two.
- MAX_LINES, 312, frame-buffer lines; rows at or beyond this are dropped.
- FIFO_DEPTH, 4, pixel write FIFO entries; power of two, at least 2.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte strobe; its rising edge qualifies a byte.
- ioctl_addr  in  25  file byte offset.
- ioctl_dout  in  8  file byte.
- wr_req  out  1  write request; a toggle means a new request.
- wr_ack  in  1  acknowledge; a request is complete when wr_ack == wr_req.
- wr_addr  out  ADDR_W  word address, held while a request is pending.
- wr_data  out  32  {8'h00,R,G,B}, held while a request is pending.
- busy  out  1  parse active or FIFO non-empty.
- loaded  out  1  image completely written.
- error  out  1  sticky until the next download starts.
- err_code  out  3  1=bad magic, 2=unsupported bpp, 3=zero size, 4=FIFO overflow, 5=truncated file.
- img_width  out  16  width from the header.
- img_height  out  16  absolute height from the header.

Behaviour:
- Reset state: all outputs 0 (wr_req=0, loaded=0, error=0, err_code=0, img_*=0, busy=0); FSM in IDLE; FIFO empty.
- Byte accept: at most one byte per clock, when ioctl_download=1 and ioctl_wr goes 0 to 1 (registered edge detect).
- Download start (rising edge of ioctl_download): clears loaded, error, err_code and all counters; FSM goes to HEADER.
- HEADER state, bytes captured by ioctl_addr:
  - bytes 0-1 must be 'B','M';
  - bytes 10-13 give the data offset (24 bits kept);
  - bytes 18-21 give the width (16 bits kept);
  - bytes 22-25 give the height (32-bit signed);
  - bytes 28-29 give bpp.
- Checks on the byte at ioctl_addr==29:
  - magic wrong -> ERR(1);
  - bpp not 24 or 32 -> ERR(2);
  - width 0 or |height| 0 -> ERR(3);
  - otherwise go to SKIP.
- Orientation: negative height means top-down; img_height = |height|.
- SKIP state: bytes discarded until ioctl_addr == offset-1. The byte at the offset is consumed as the first pixel byte, then go to PIXEL.
- PIXEL state: bytes arrive in order B,G,R[,A].
  - After the last byte of a pixel, {00,R,G,B} is pushed with address line*LINE_WORDS + x.
  - line = height-1-y for bottom-up files; line = y for top-down files.
  - The push is suppressed (pixel clipped, counters still advance) if x >= LINE_WORDS or line >= MAX_LINES.
- Row end: after width pixels, skip pad = (4 - (width*bytes_per_pixel mod 4)) mod 4 bytes, then x=0 and y++.
- Image end: after y == |height|, go to DONE and ignore further bytes.
- Write port:
  - when wr_req == wr_ack and the FIFO is non-empty, pop into wr_addr/wr_data and toggle wr_req in the same cycle;
  - at most one request is outstanding.
- Simultaneous push and pop are allowed. A push into a full FIFO drops the pixel and gives ERR(4); the source cannot be stalled.
- Falling edge of ioctl_download:
  - in DONE, loaded=1 once the FIFO is empty and wr_req == wr_ack;
  - in HEADER, SKIP or PIXEL -> ERR(5).
- ERR state: FIFO flushed, no new requests; an outstanding request is allowed to complete. Leaves ERR only on a new download start.
- Address arithmetic is in ADDR_W bits; wrap beyond 2^ADDR_W is not checked.
- Reset asserted mid-operation clears everything immediately. An outstanding toggle is lost; the SDRAM side is reset in the same domain.

Test Plan:
- 4x2 24bpp bottom-up, offset 54, ack 1 cycle later.
  - Required: 8 writes; row 1 of the file at line 0 and row 0 at line 1, addresses 0..3 and 512..515 (LINE_WORDS=512, MAX_LINES=2).
  - Required: each row consumes 12 bytes with no padding; loaded=1 after download ends.
- 3x1 24bpp, 9 pixel bytes then 3 pad bytes.
  - Required: 3 writes with data 0x00RRGGBB from B,G,R order; pad ignored; loaded=1.
- 2x2 32bpp with height=-2 (top-down).
  - Required: first file row at addresses 0,1, second at 512,513; the alpha byte is discarded.
- Width 600 with LINE_WORDS=512.
  - Required: columns 512..599 not written; next row begins correctly.
- Ack held off 50 cycles with bytes every 2 cycles.
  - Required: error=1, err_code=4; no further wr_req toggles after the pending ack.
- Error cases:
  - header 'BX' -> err_code=1;
  - bpp=8 -> err_code=2;
  - download dropped mid-pixel -> err_code=5, loaded stays 0;
  - reset_n low mid-PIXEL -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/bmp_stream_loader.sv
// Streams a BMP file from the data_io byte interface into the SDRAM frame buffer
// as {8'h00,R,G,B} words, with header decode, row padding, clipping and status.
module bmp_stream_loader #(
  parameter int ADDR_W     = 22,
  parameter int LINE_WORDS = 512,
  parameter int MAX_LINES  = 312,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              loaded,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height
);

  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LW_LIM = LINE_WORDS;
  localparam logic [31:0] ML_LIM = MAX_LINES;
  localparam logic [2:0] ERR_MAGIC = 3'd1;
  localparam logic [2:0] ERR_BPP   = 3'd2;
  localparam logic [2:0] ERR_SIZE  = 3'd3;
  localparam logic [2:0] ERR_OVF   = 3'd4;
  localparam logic [2:0] ERR_TRUNC = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_SKIP, S_PIXEL, S_DONE, S_ERR} state_t;

  function automatic logic [31:0] abs_height(input logic signed [31:0] h);
    return h[31] ? $unsigned(-h) : $unsigned(h);
  endfunction

  // Rows are padded to 4 bytes; 3*w mod 4 padding reduces to w mod 4.
  function automatic logic [1:0] row_pad(input logic [15:0] w, input logic is32);
    return is32 ? 2'd0 : w[1:0];
  endfunction

  state_t state, state_next;
  logic [2:0] err_next;
  logic       err_enter, flush;

  logic ioctl_wr_p0, ioctl_download_p0;
  logic byte_stb, dl_rise, dl_fall;

  logic [7:0]         magic0, magic1, bpp_lo;
  logic [23:0]        data_offset;
  logic [15:0]        hdr_width;
  logic signed [31:0] hdr_height;
  logic [15:0]        bpp_val;
  logic [31:0]        height_abs;
  logic               hdr_last;

  logic        top_down, bpp32, end_seen;
  logic [1:0]  bcnt, pad_cnt;
  logic [15:0] x_cnt, y_cnt, px_line;
  logic [7:0]  pix_b, pix_g, pix_r;
  logic        pix_byte, pad_byte, px_last, row_last, row_end, img_end, clipped;
  logic [ADDR_W-1:0] px_addr;
  logic [31:0]       px_data;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              push, pop, overflow, do_push;

  // Stage p0: registered strobe and download edges
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wr_p0       <= 1'b0;
      ioctl_download_p0 <= 1'b0;
    end else begin
      ioctl_wr_p0       <= ioctl_wr;
      ioctl_download_p0 <= ioctl_download;
    end
  end

  assign dl_rise  = ioctl_download & ~ioctl_download_p0;
  assign dl_fall  = ~ioctl_download & ioctl_download_p0;
  assign byte_stb = ioctl_download & ioctl_wr & ~ioctl_wr_p0;

  assign hdr_last   = byte_stb && (state == S_HEADER) && (ioctl_addr == 25'd29);
  assign bpp_val    = {ioctl_dout, bpp_lo};
  assign height_abs = abs_height(hdr_height);

  // SKIP hands the byte at the data offset straight to the pixel walker.
  assign pix_byte = byte_stb && (state == S_PIXEL ||
                    (state == S_SKIP && ioctl_addr >= {1'b0, data_offset}));
  assign pad_byte = pix_byte && (pad_cnt != 2'd0);
  assign px_last  = pix_byte && (pad_cnt == 2'd0) && (bcnt == (bpp32 ? 2'd3 : 2'd2));
  assign row_last = px_last && (x_cnt == img_width - 16'd1);
  assign row_end  = (row_last && row_pad(img_width, bpp32) == 2'd0) ||
                    (pad_byte && pad_cnt == 2'd1);
  assign img_end  = row_end && (y_cnt == img_height - 16'd1);

  assign px_line = top_down ? y_cnt : (img_height - 16'd1 - y_cnt);
  assign clipped = ({16'd0, x_cnt} >= LW_LIM) || ({16'd0, px_line} >= ML_LIM);
  assign px_addr = (ADDR_W'(px_line) << LW_BITS) + ADDR_W'(x_cnt);
  assign px_data = {8'h00, (bpp32 ? pix_r : ioctl_dout), pix_g, pix_b};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 3'd0;
    if (dl_rise) begin
      state_next = S_HEADER;
    end else begin
      unique case (state)
        S_HEADER: begin
          if (dl_fall) err_next = ERR_TRUNC;
          else if (hdr_last) begin
            if (magic0 != 8'h42 || magic1 != 8'h4D)         err_next = ERR_MAGIC;
            else if (bpp_val != 16'd24 && bpp_val != 16'd32) err_next = ERR_BPP;
            else if (hdr_width == 16'd0 || height_abs == 32'd0) err_next = ERR_SIZE;
            else state_next = S_SKIP;
          end
        end
        S_SKIP, S_PIXEL: begin
          if (dl_fall)       err_next   = ERR_TRUNC;
          else if (overflow) err_next   = ERR_OVF;
          else if (img_end)  state_next = S_DONE;
          else if (pix_byte) state_next = S_PIXEL;
        end
        default: ;
      endcase
      if (err_next != 3'd0) state_next = S_ERR;
    end
  end

  always_comb begin
    busy     = (state == S_HEADER) || (state == S_SKIP) || (state == S_PIXEL) || !fifo_empty;
    push     = px_last && !clipped;
    pop      = (wr_req == wr_ack) && !fifo_empty && (state != S_ERR) && !dl_rise;
    overflow = push && fifo_full && !pop;
    do_push  = push && !overflow;
  end

  assign err_enter = (err_next != 3'd0);
  assign flush     = dl_rise || err_enter;

  always_ff @(posedge clk_sys) begin
    if (byte_stb && state == S_HEADER) begin
      case (ioctl_addr)
        25'd0:  magic0            <= ioctl_dout;
        25'd1:  magic1            <= ioctl_dout;
        25'd10: data_offset[7:0]  <= ioctl_dout;
        25'd11: data_offset[15:8] <= ioctl_dout;
        25'd12: data_offset[23:16] <= ioctl_dout;
        25'd18: hdr_width[7:0]    <= ioctl_dout;
        25'd19: hdr_width[15:8]   <= ioctl_dout;
        25'd22: hdr_height[7:0]   <= ioctl_dout;
        25'd23: hdr_height[15:8]  <= ioctl_dout;
        25'd24: hdr_height[23:16] <= ioctl_dout;
        25'd25: hdr_height[31:24] <= ioctl_dout;
        25'd28: bpp_lo            <= ioctl_dout;
        default: ;
      endcase
    end
    if (pix_byte && pad_cnt == 2'd0) begin
      case (bcnt)
        2'd0:    pix_b <= ioctl_dout;
        2'd1:    pix_g <= ioctl_dout;
        2'd2:    pix_r <= ioctl_dout;
        default: ;
      endcase
    end
    if (do_push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= px_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= px_data;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      loaded     <= 1'b0;
      error      <= 1'b0;
      err_code   <= 3'd0;
      img_width  <= 16'd0;
      img_height <= 16'd0;
      top_down   <= 1'b0;
      bpp32      <= 1'b0;
      bcnt       <= 2'd0;
      pad_cnt    <= 2'd0;
      x_cnt      <= 16'd0;
      y_cnt      <= 16'd0;
      end_seen   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (hdr_last) begin
        img_width  <= hdr_width;
        img_height <= height_abs[15:0];
        top_down   <= hdr_height[31];
        bpp32      <= (bpp_val == 16'd32);
      end
      if (pix_byte) begin
        if (pad_cnt != 2'd0) begin
          pad_cnt <= pad_cnt - 2'd1;
        end else if (px_last) begin
          bcnt  <= 2'd0;
          x_cnt <= x_cnt + 16'd1;
          if (row_last) pad_cnt <= row_pad(img_width, bpp32);
        end else begin
          bcnt <= bcnt + 2'd1;
        end
        if (row_end) begin
          x_cnt <= 16'd0;
          y_cnt <= y_cnt + 16'd1;
        end
      end
      // loaded waits for the last write to be acknowledged after download ends
      if (state == S_DONE && dl_fall) end_seen <= 1'b1;
      if (state == S_DONE && end_seen && fifo_empty && wr_req == wr_ack) loaded <= 1'b1;
      if (pop) begin
        wr_addr <= fifo_addr[rd_ptr[PTR_W-1:0]];
        wr_data <= fifo_data[rd_ptr[PTR_W-1:0]];
        wr_req  <= ~wr_req;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
      if (dl_rise) begin
        loaded   <= 1'b0;
        error    <= 1'b0;
        err_code <= 3'd0;
        bcnt     <= 2'd0;
        pad_cnt  <= 2'd0;
        x_cnt    <= 16'd0;
        y_cnt    <= 16'd0;
        end_seen <= 1'b0;
      end else if (err_enter) begin
        error    <= 1'b1;
        err_code <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_loader.sv
// Bench for bmp_stream_loader: builds BMP files in memory, streams them in and
// compares SDRAM writes and status against a per-pixel reference model.
module tb_bmp_stream_loader;
  localparam int ADDR_W = 22;
  localparam int LW     = 512;
  localparam int ML     = 2;
  localparam int FD     = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              wr_req;
  logic              wr_ack = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy, loaded, error;
  logic [2:0]        err_code;
  logic [15:0]       img_width, img_height;

  always #5 clk_sys = ~clk_sys;

  bmp_stream_loader #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .MAX_LINES(ML), .FIFO_DEPTH(FD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .loaded(loaded), .error(error), .err_code(err_code),
    .img_width(img_width), .img_height(img_height));

  int errors = 0;
  int checks = 0;
  int ack_delay = 1;

  logic [7:0]        file_q[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];

  // SDRAM side: records each new request and acknowledges it ack_delay cycles later
  initial begin : sdram
    int  cnt;
    bit  pending;
    cnt = 0;
    pending = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        wr_ack = 1'b0;
        pending = 0;
      end else if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          wr_ack = wr_req;
          pending = 0;
        end
      end else if (wr_req !== wr_ack) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        pending = 1;
        cnt = ack_delay;
      end
    end
  end

  task automatic build_bmp(input int w, input int h, input int bpp, input int off,
                           input logic [7:0] m1);
    int habs, bpb, pad, ln;
    logic [31:0] w32, h32, o32, b32;
    logic [7:0] r, g, b;
    file_q.delete();
    exp_addr.delete();
    exp_data.delete();
    habs = (h < 0) ? -h : h;
    bpb  = bpp / 8;
    pad  = (4 - ((w * bpb) % 4)) % 4;
    for (int i = 0; i < off; i++) file_q.push_back(8'h00);
    file_q[0] = 8'h42;
    file_q[1] = m1;
    w32 = w; h32 = h; o32 = off; b32 = bpp;
    for (int k = 0; k < 4; k++) begin
      file_q[10+k] = o32[8*k +: 8];
      file_q[18+k] = w32[8*k +: 8];
      file_q[22+k] = h32[8*k +: 8];
    end
    file_q[28] = b32[7:0];
    file_q[29] = b32[15:8];
    for (int row = 0; row < habs; row++) begin
      ln = (h < 0) ? row : habs - 1 - row;
      for (int x = 0; x < w; x++) begin
        b = 8'($urandom);
        g = 8'($urandom);
        r = 8'($urandom);
        file_q.push_back(b);
        file_q.push_back(g);
        file_q.push_back(r);
        if (bpb == 4) file_q.push_back(8'($urandom));
        if (x < LW && ln < ML) begin
          exp_addr.push_back(ADDR_W'(ln * LW + x));
          exp_data.push_back({8'h00, r, g, b});
        end
      end
      for (int p = 0; p < pad; p++) file_q.push_back(8'($urandom));
    end
  endtask

  task automatic start_dl();
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send_bytes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk_sys);
      ioctl_addr = 25'(i);
      ioctl_dout = file_q[i];
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
    end
  endtask

  task automatic end_dl();
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++; if (wr_req !== 1'b0)   begin errors++; $display("FAIL reset wr_req: got %b want 0", wr_req); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (loaded !== 1'b0)   begin errors++; $display("FAIL reset loaded: got %b want 0", loaded); end
    checks++; if (error !== 1'b0 || err_code !== 3'd0)
      begin errors++; $display("FAIL reset error: got %b/%0d want 0/0", error, err_code); end
    checks++; if (img_width !== 16'd0 || img_height !== 16'd0)
      begin errors++; $display("FAIL reset img: got %0d x %0d want 0 x 0", img_width, img_height); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_image(input string name, input int w, input int h, input int bpp,
                            input int off, input int first_a, input int last_a);
    int n, habs;
    logic [ADDR_W-1:0] got;
    habs = (h < 0) ? -h : h;
    build_bmp(w, h, bpp, off, 8'h4D);
    start_dl();
    send_bytes(0, file_q.size());
    end_dl();
    for (int i = 0; i < 4000 && loaded !== 1'b1; i++) @(negedge clk_sys);
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL %s loaded: got %b want 1", name, loaded); end
    checks++; if (error !== 1'b0)  begin errors++; $display("FAIL %s error: got %b code %0d want 0", name, error, err_code); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL %s busy: got %b want 0", name, busy); end
    checks++; if (img_width !== 16'(w) || img_height !== 16'(habs))
      begin errors++; $display("FAIL %s size: got %0dx%0d want %0dx%0d", name, img_width, img_height, w, habs); end
    checks++; if (cap_addr.size() != exp_addr.size())
      begin errors++; $display("FAIL %s writes: got %0d want %0d", name, cap_addr.size(), exp_addr.size()); end
    n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s write %0d: got %0h:%08h want %0h:%08h", name, i,
                 cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (first_a >= 0) begin
      got = (cap_addr.size() > 0) ? cap_addr[0] : '1;
      checks++; if (got !== ADDR_W'(first_a))
        begin errors++; $display("FAIL %s first addr: got %0d want %0d", name, got, first_a); end
      got = (cap_addr.size() > 0) ? cap_addr[cap_addr.size()-1] : '1;
      checks++; if (got !== ADDR_W'(last_a))
        begin errors++; $display("FAIL %s last addr: got %0d want %0d", name, got, last_a); end
    end
  endtask

  task automatic test_random();
    int w, h, bpp, off;
    for (int k = 0; k < 4; k++) begin
      w   = $urandom_range(1, 9);
      h   = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) h = -h;
      bpp = ($urandom_range(0, 1) == 1) ? 32 : 24;
      off = $urandom_range(54, 60);
      test_image("random", w, h, bpp, off, -1, -1);
    end
  endtask

  task automatic test_bad_magic();
    build_bmp(2, 2, 24, 54, 8'h58);
    start_dl();
    send_bytes(0, file_q.size());
    end_dl();
    repeat (10) @(negedge clk_sys);
    checks++; if (error !== 1'b1 || err_code !== 3'd1)
      begin errors++; $display("FAIL bad_magic code: got %b/%0d want 1/1", error, err_code); end
    checks++; if (cap_addr.size() != 0 || loaded !== 1'b0)
      begin errors++; $display("FAIL bad_magic writes: got %0d loaded %b want 0/0", cap_addr.size(), loaded); end
  endtask

  task automatic test_bad_bpp();
    build_bmp(2, 2, 8, 54, 8'h4D);
    start_dl();
    checks++; if (error !== 1'b0 || err_code !== 3'd0)
      begin errors++; $display("FAIL start_clears_error: got %b/%0d want 0/0", error, err_code); end
    send_bytes(0, file_q.size());
    end_dl();
    repeat (10) @(negedge clk_sys);
    checks++; if (error !== 1'b1 || err_code !== 3'd2)
      begin errors++; $display("FAIL bad_bpp code: got %b/%0d want 1/2", error, err_code); end
    checks++; if (cap_addr.size() != 0)
      begin errors++; $display("FAIL bad_bpp writes: got %0d want 0", cap_addr.size()); end
  endtask

  task automatic test_zero_size();
    build_bmp(0, 2, 24, 54, 8'h4D);
    start_dl();
    send_bytes(0, file_q.size());
    end_dl();
    repeat (10) @(negedge clk_sys);
    checks++; if (error !== 1'b1 || err_code !== 3'd3)
      begin errors++; $display("FAIL zero_size code: got %b/%0d want 1/3", error, err_code); end
  endtask

  task automatic test_truncated();
    build_bmp(4, 2, 24, 54, 8'h4D);
    start_dl();
    send_bytes(0, 64);
    end_dl();
    repeat (20) @(negedge clk_sys);
    checks++; if (error !== 1'b1 || err_code !== 3'd5)
      begin errors++; $display("FAIL truncated code: got %b/%0d want 1/5", error, err_code); end
    checks++; if (loaded !== 1'b0)
      begin errors++; $display("FAIL truncated loaded: got %b want 0", loaded); end
  endtask

  task automatic test_overflow();
    ack_delay = 50;
    build_bmp(4, 2, 24, 54, 8'h4D);
    start_dl();
    send_bytes(0, file_q.size());
    end_dl();
    repeat (100) @(negedge clk_sys);
    checks++; if (error !== 1'b1 || err_code !== 3'd4)
      begin errors++; $display("FAIL overflow code: got %b/%0d want 1/4", error, err_code); end
    checks++; if (cap_addr.size() != 1)
      begin errors++; $display("FAIL overflow requests: got %0d want 1", cap_addr.size()); end
    checks++; if (cap_addr.size() > 0 && (cap_addr[0] !== exp_addr[0] || cap_data[0] !== exp_data[0]))
      begin errors++; $display("FAIL overflow first write: got %0h:%08h want %0h:%08h",
                               cap_addr[0], cap_data[0], exp_addr[0], exp_data[0]); end
    checks++; if (wr_req !== wr_ack || loaded !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL overflow idle: got req %b ack %b loaded %b busy %b want req=ack,0,0",
                               wr_req, wr_ack, loaded, busy); end
    ack_delay = 1;
  endtask

  task automatic test_reset_mid_pixel();
    build_bmp(4, 2, 24, 54, 8'h4D);
    start_dl();
    send_bytes(0, 61);
    checks++; if (busy !== 1'b1 || img_width !== 16'd4)
      begin errors++; $display("FAIL midpixel pre: got busy %b width %0d want 1/4", busy, img_width); end
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (wr_req !== 1'b0 || wr_addr !== '0 || wr_data !== 32'd0)
      begin errors++; $display("FAIL midpixel wr: got %b %0h %08h want 0 0 0", wr_req, wr_addr, wr_data); end
    checks++; if (busy !== 1'b0 || loaded !== 1'b0 || error !== 1'b0 || err_code !== 3'd0)
      begin errors++; $display("FAIL midpixel status: got %b %b %b %0d want 0 0 0 0", busy, loaded, error, err_code); end
    checks++; if (img_width !== 16'd0 || img_height !== 16'd0)
      begin errors++; $display("FAIL midpixel img: got %0dx%0d want 0x0", img_width, img_height); end
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    checks++; if (error !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midpixel after: got %b %b %b want 0 0 0", error, loaded, busy); end
  endtask

  initial begin
    test_reset();
    test_image("bottom_up_4x2", 4, 2, 24, 54, 512, 3);
    test_image("pad_3x1", 3, 1, 24, 54, 0, 2);
    test_image("top_down_32", 2, -2, 32, 54, 0, 513);
    test_image("wide_clip", 600, 2, 24, 54, 512, 511);
    test_random();
    test_bad_magic();
    test_bad_bpp();
    test_zero_size();
    test_truncated();
    test_overflow();
    test_reset_mid_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
